ste_adc_sampler: RTL and testbench
==================================

Name: ste_adc_sampler

Overview:
- Producer side of the multimeter sample stream: paces ADC reads and emits data samples plus a one-cycle update strobe, which feed the averaging filter's din/din_update inputs.
- Issues periodic single reads over the XADC DRP port, one every programmable number of clocks.
- Captures the result and outputs it with a one-cycle update strobe.
- Generates the average-clear pulse whenever the sampling context changes.

Parameters:
- DATA_W, 16: output sample width; legal range 1..16; MSB-aligned slice of the DRP word.
- DIV_W, 24: width of the sample-period divider.
- TIMEOUT, 255: maximum clk cycles to wait for drp_drdy_i after a request.
- DRP_ADDR, 7'h03: DRP status register read every sample (default VP/VN).

Ports:
- clk  in  1  System clock.
- rst_n  in  1  Asynchronous reset, active low.
- enable_i  in  1  Sampling enable.
- sample_div_i  in  DIV_W  Sample period minus 1, in clk cycles.
- drp_den_o  out  1  DRP enable, one-cycle pulse per read.
- drp_daddr_o  out  7  DRP address; constant DRP_ADDR.
- drp_drdy_i  in  1  DRP read data valid.
- drp_do_i  in  16  DRP read data.
- dout_o  out  DATA_W  Last captured sample, drp_do_i[15 -: DATA_W].
- dout_update_o  out  1  One-cycle strobe: dout_o holds a new sample.
- avg_clr_o  out  1  One-cycle pulse requesting the averager to clear.
- busy_o  out  1  High from request until the DRP transaction ends.
- timeout_o  out  1  Sticky; set on DRP timeout, cleared on enable_i rising edge.
- overrun_cnt_o  out  8  Dropped-tick counter (optional feature; otherwise 0).

Behaviour:
- Reset values: dout_o 0, dout_update_o 0, drp_den_o 0, avg_clr_o 0, busy_o 0, timeout_o 0, overrun_cnt_o 0; FSM in IDLE; timer = 0.
- Timer:
  - Counts down while enable_i = 1.
  - On reaching 0 it asserts an internal tick for one cycle and reloads sample_div_i.
  - When enable_i = 0 it is held at 0, so the first tick comes the cycle after enable_i rises.
  - Tick period is sample_div_i + 1 cycles.
- FSM states: IDLE, WAIT_TICK, REQ, WAIT_RDY, OUT.
  - IDLE -> WAIT_TICK when enable_i = 1.
  - WAIT_TICK -> REQ on tick.
  - REQ: drp_den_o = 1 for exactly one cycle; busy_o = 1; timeout counter cleared; next state WAIT_RDY.
  - WAIT_RDY, on drp_drdy_i = 1: capture drp_do_i, go to OUT.
  - WAIT_RDY, after TIMEOUT cycles with no drdy: set timeout_o, go to WAIT_TICK; no update is emitted.
  - OUT: dout_o updated, dout_update_o = 1 for one cycle, busy_o = 0; next state is WAIT_TICK, or IDLE if enable_i = 0.
- Latency:
  - Tick at cycle T gives drp_den_o at T+1.
  - drdy at cycle R gives dout_o/dout_update_o at R+1.
  - With a zero-wait DRP, tick to update is 3 cycles.
- Overrun: a tick arriving in any state other than WAIT_TICK is dropped. No request is queued.
- Disable mid-transaction:
  - A request already issued is always allowed to finish; no second den is ever issued before drdy or timeout.
  - If enable_i = 0 when drdy arrives, the data is discarded: no update strobe, dout_o is unchanged, and the FSM goes to IDLE.
  - Disable in WAIT_TICK or REQ-pending goes to IDLE immediately; a den already driven in REQ still completes as above.
- avg_clr_o: one-cycle pulse, registered, 1 cycle after either event:
  - rising edge of enable_i;
  - a change of sample_div_i while enable_i = 1 (compared against a registered copy).
  - Simultaneous events produce a single pulse.
- dout_update_o and avg_clr_o in the same cycle are both asserted. The consumer applies the clear first.
- drdy outside WAIT_RDY is ignored.
- dout_o holds its value between updates and is not cleared by disable.
- Asynchronous reset at any point returns all state to reset values immediately.

Optional Feature:
- Macro: STE_SMP_OVERRUN_CNT_EN.
- Defined:
  - overrun_cnt_o increments on each dropped tick and saturates at 255.
  - It is cleared on enable_i rising edge.
- Undefined: overrun_cnt_o is tied to 0 and no counter logic is built; all other behaviour is unchanged.

Test Plan:
1. Reset, enable_i = 1, sample_div_i = 99, DRP model drdy 2 cycles after den with data 16'hABC0 -> den every 100 cycles; dout_o = 16'hABC0 with a one-cycle update 3 cycles after den; avg_clr_o pulses once, 1 cycle after enable rises.
2. DRP model never asserts drdy, TIMEOUT = 255 -> timeout_o sets 256 cycles after den; no dout_update_o; next den on the following tick; timeout_o clears on the next enable rising edge.
3. sample_div_i = 1, drdy latency 4 -> exactly one den outstanding at a time; with the macro defined, overrun_cnt_o increments per dropped tick and saturates at 255 after a long run.
4. enable_i dropped 1 cycle after den, drdy 3 cycles later -> no update, dout_o unchanged, busy_o falls after drdy, FSM in IDLE.
5. sample_div_i changed 99 -> 49 while enabled -> single avg_clr_o pulse 1 cycle later; subsequent den spacing 50 cycles after the current reload.
6. rst_n asserted while in WAIT_RDY -> all outputs are 0 during reset; after release with enable_i held at 1 -> first den 2 cycles later, plus an avg_clr_o pulse.

Source files
------------

// File: rtl/ste_adc_sampler_if.sv
// rtl/ste_adc_sampler_if.sv - XADC DRP read port bundle for the ADC sampler
//
// Purpose: groups the DRP read handshake between the sampler (master) and
// the XADC DRP port (slave).
// Signals:
//   drp_den_o    master->slave  one-cycle read enable
//   drp_daddr_o  master->slave  7-bit register address
//   drp_drdy_i   slave->master  read data valid
//   drp_do_i     slave->master  16-bit read data
interface ste_adc_sampler_if;
    logic        drp_den_o;
    logic [6:0]  drp_daddr_o;
    logic        drp_drdy_i;
    logic [15:0] drp_do_i;

    modport master (
        output drp_den_o,
        output drp_daddr_o,
        input  drp_drdy_i,
        input  drp_do_i
    );

    modport slave (
        input  drp_den_o,
        input  drp_daddr_o,
        output drp_drdy_i,
        output drp_do_i
    );
endinterface

// File: rtl/ste_adc_sampler.sv
// rtl/ste_adc_sampler.sv - paced XADC DRP reader producing a sample stream
//
// Purpose: issues one DRP read every sample_div_i+1 clocks, captures the
// MSB-aligned result and presents it with a one-cycle update strobe; raises
// a one-cycle averager clear whenever the sampling context changes.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          sampling enable
//   sample_div_i      sample period minus one, in clk cycles
//   drp               DRP read port (master side of ste_adc_sampler_if)
//   dout_o            last captured sample, drp_do_i[15 -: DATA_W]
//   dout_update_o     one-cycle strobe, dout_o holds a new sample
//   avg_clr_o         one-cycle averager clear request
//   busy_o            high from request until the DRP transaction ends
//   timeout_o         sticky DRP timeout flag, cleared on enable rising edge
//   overrun_cnt_o     saturating dropped-tick counter
// Optional feature macro: STE_SMP_OVERRUN_CNT_EN builds the dropped-tick
// counter; without it overrun_cnt_o is tied to zero.
module ste_adc_sampler #(
    parameter int         DATA_W   = 16,
    parameter int         DIV_W    = 24,
    parameter int         TIMEOUT  = 255,
    parameter logic [6:0] DRP_ADDR = 7'h03
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [DIV_W-1:0]     sample_div_i,
    ste_adc_sampler_if.master    drp,
    output logic [DATA_W-1:0]    dout_o,
    output logic                 dout_update_o,
    output logic                 avg_clr_o,
    output logic                 busy_o,
    output logic                 timeout_o,
    output logic [7:0]           overrun_cnt_o
);

    // Wait counter runs 0..TIMEOUT-1 across the WAIT_RDY cycles.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        REQ,
        WAIT_RDY,
        OUT
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    timer_q, timer_d;
    logic                tick_q, tick_d;
    logic                en_q;
    logic [DIV_W-1:0]    div_q;
    logic                avg_clr_q, avg_clr_d;
    logic                den_q;
    logic                busy_q;
    logic                upd_q;
    logic                timeout_q;
    logic [DATA_W-1:0]   dout_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                en_rise;

    assign en_rise = enable_i & ~en_q;

    // Timer is parked at zero while disabled so the first tick lands on the
    // cycle right after enable rises; the tick itself is registered.
    always_comb begin
        timer_d = timer_q;
        tick_d  = 1'b0;
        if (!enable_i) begin
            timer_d = '0;
        end else if (timer_q == '0) begin
            timer_d = sample_div_i;
            tick_d  = 1'b1;
        end else begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Enable edge and divider change share one pulse, so coincident events
    // collapse naturally.
    always_comb begin
        avg_clr_d = en_rise | (enable_i & (sample_div_i != div_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            tick_q    <= 1'b0;
            en_q      <= 1'b0;
            div_q     <= '0;
            avg_clr_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            tick_q    <= tick_d;
            en_q      <= enable_i;
            div_q     <= sample_div_i;
            avg_clr_q <= avg_clr_d;
        end
    end

    // Request sequencer. A den already issued is always run to drdy or
    // timeout, so at most one read is ever outstanding; ticks seen outside
    // WAIT_TICK are simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            den_q     <= 1'b0;
            busy_q    <= 1'b0;
            upd_q     <= 1'b0;
            timeout_q <= 1'b0;
            dout_q    <= '0;
            to_cnt_q  <= '0;
        end else begin
            den_q <= 1'b0;
            upd_q <= 1'b0;
            if (en_rise) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        state_q <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (tick_q) begin
                        state_q <= REQ;
                        den_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                REQ: begin
                    to_cnt_q <= '0;
                    state_q  <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (drp.drp_drdy_i) begin
                        busy_q <= 1'b0;
                        if (enable_i) begin
                            dout_q  <= drp.drp_do_i[15 -: DATA_W];
                            upd_q   <= 1'b1;
                            state_q <= OUT;
                        end else begin
                            // Disabled while in flight: drop the data.
                            state_q <= IDLE;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= WAIT_TICK;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    state_q <= enable_i ? WAIT_TICK : IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef STE_SMP_OVERRUN_CNT_EN
    logic [7:0] ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else if (en_rise) begin
            ovr_q <= '0;
        end else if (tick_q && (state_q != WAIT_TICK) && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 1'b1;
        end
    end

    assign overrun_cnt_o = ovr_q;
`else
    assign overrun_cnt_o = '0;
`endif

    assign drp.drp_den_o   = den_q;
    assign drp.drp_daddr_o = DRP_ADDR;
    assign dout_o          = dout_q;
    assign dout_update_o   = upd_q;
    assign avg_clr_o       = avg_clr_q;
    assign busy_o          = busy_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_ste_adc_sampler.sv
// tb/tb_ste_adc_sampler.sv - self-checking bench for ste_adc_sampler
module tb_ste_adc_sampler;
    localparam int DW   = 16;
    localparam int DIVW = 24;
    localparam int LOGN = 8192;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic [DIVW-1:0] div = DIVW'(99);
    logic [DW-1:0]   dout;
    logic            upd, clr, busy, tmo;
    logic [7:0]      ovr;

    ste_adc_sampler_if drp ();

    ste_adc_sampler #(
        .DATA_W(DW), .DIV_W(DIVW), .TIMEOUT(255), .DRP_ADDR(7'h03)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable_i(enable),
        .sample_div_i(div),
        .drp(drp),
        .dout_o(dout),
        .dout_update_o(upd),
        .avg_clr_o(clr),
        .busy_o(busy),
        .timeout_o(tmo),
        .overrun_cnt_o(ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DRP slave model plus per-cycle output log. bit0 den, bit1 update,
    // bit2 avg_clr, bit3 busy, bit4 timeout.
    int          drp_lat = 2;
    bit          drp_never = 1'b0;
    bit          fixed_en = 1'b1;
    logic [15:0] fixed_data = 16'hABC0;
    int          rsp_cnt = 0;
    logic [15:0] rsp_data = '0;
    int          den_overlap = 0;
    logic [4:0]  lg      [0:LOGN-1];
    logic [DW-1:0] dout_lg [0:LOGN-1];
    logic [7:0]  ovr_lg  [0:LOGN-1];
    logic [15:0] rsp_lg  [0:LOGN-1];

    initial begin
        drp.drp_drdy_i = 1'b0;
        drp.drp_do_i   = '0;
    end

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            lg[cyc]      = {tmo, busy, clr, upd, drp.drp_den_o};
            dout_lg[cyc] = dout;
            ovr_lg[cyc]  = ovr;
        end
        drp.drp_drdy_i = 1'b0;
        drp.drp_do_i   = 16'($urandom);
        if (!rst_n) begin
            rsp_cnt = 0;
        end else begin
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    drp.drp_drdy_i = 1'b1;
                    drp.drp_do_i   = rsp_data;
                    if (cyc < LOGN) rsp_lg[cyc] = rsp_data;
                end
            end
            if (drp.drp_den_o) begin
                if (rsp_cnt > 0) den_overlap++;
                if (!drp_never) begin
                    rsp_cnt  = drp_lat;
                    rsp_data = fixed_en ? fixed_data : 16'($urandom);
                end
            end
        end
    end

    function automatic int nth_ev(int b, int lo, int hi, int n);
        int k = 0;
        for (int c = lo; c <= hi && c < LOGN; c++) begin
            if (lg[c][b]) begin
                if (k == n) return c;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic int cnt_ev(int b, int lo, int hi);
        int k = 0;
        for (int c = lo; c <= hi && c < LOGN; c++) if (lg[c][b]) k++;
        return k;
    endfunction

    function automatic logic bit_at(int b, int c);
        if (c < 0 || c >= LOGN) return 1'bx;
        return lg[c][b];
    endfunction

    function automatic logic [DW-1:0] dout_at(int c);
        if (c < 0 || c >= LOGN) return 'x;
        return dout_lg[c];
    endfunction

    // Expected sample for an update at cycle c: the DRP word returned one
    // cycle earlier, MSB-aligned to DW bits.
    function automatic logic [DW-1:0] exp_sample(int c);
        logic [15:0] w;
        if (c < 1 || c >= LOGN) return 'x;
        w = rsp_lg[c-1];
        return w[15 -: DW];
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e, e2, c, r, d, u, p, lat;
        logic [DW-1:0] prev;

        idle_cycles(3);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_upd", 32'(upd), 0);
        chk("rst_den", 32'(drp.drp_den_o), 0);
        chk("rst_clr", 32'(clr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_ovr", 32'(ovr), 0);
        chk("daddr", 32'(drp.drp_daddr_o), 32'h03);
        rst_n = 1'b1;
        idle_cycles(2);

        // Nominal pacing, fixed DRP data, two-cycle DRP latency.
        enable = 1'b1;
        e = cyc;
        wait_to(e + 215);
        chk("t1_den_cnt", cnt_ev(0, e, e + 214), 3);
        for (int k = 0; k < 3; k++) begin
            d = nth_ev(0, e, e + 214, k);
            u = nth_ev(1, e, e + 214, k);
            chk("t1_den_at", d, e + 2 + 100 * k);
            chk("t1_upd_at", u, e + 5 + 100 * k);
            chk("t1_data", 32'(dout_at(u)), 32'(fixed_data[15 -: DW]));
        end
        chk("t1_clr_cnt", cnt_ev(2, e, e + 214), 1);
        chk("t1_clr_at", nth_ev(2, e, e + 214, 0), e + 1);
        chk("t1_busy_den", 32'(bit_at(3, e + 2)), 1);
        chk("t1_busy_rdy", 32'(bit_at(3, e + 4)), 1);
        chk("t1_busy_out", 32'(bit_at(3, e + 5)), 0);
        chk("t1_tmo", cnt_ev(4, e, e + 214), 0);

        // Silent DRP: timeout path and sticky flag.
        enable = 1'b0;
        fixed_en = 1'b0;
        drp_never = 1'b1;
        div = DIVW'(299);
        idle_cycles(5);
        enable = 1'b1;
        e = cyc;
        wait_to(e + 320);
        chk("t2_den0", nth_ev(0, e, e + 319, 0), e + 2);
        chk("t2_tmo_at", nth_ev(4, e, e + 319, 0), e + 258);
        chk("t2_busy_pre", 32'(bit_at(3, e + 257)), 1);
        chk("t2_busy_post", 32'(bit_at(3, e + 258)), 0);
        chk("t2_no_upd", cnt_ev(1, e, e + 319), 0);
        chk("t2_den1", nth_ev(0, e, e + 319, 1), e + 302);
        wait_to(e + 570);
        enable = 1'b0;
        drp_never = 1'b0;
        drp_lat = 2;
        idle_cycles(3);
        chk("t2_tmo_sticky", 32'(tmo), 1);
        enable = 1'b1;
        e2 = cyc;
        wait_to(e2 + 3);
        enable = 1'b0;
        chk("t2_tmo_hold", 32'(bit_at(4, e2)), 1);
        chk("t2_tmo_clr", 32'(bit_at(4, e2 + 1)), 0);

        // Fast ticks with slow DRP: one request in flight, ticks dropped.
        idle_cycles(10);
        div = DIVW'(1);
        drp_lat = 4;
        den_overlap = 0;
        idle_cycles(3);
        enable = 1'b1;
        e = cyc;
        wait_to(e + 40);
        chk("t3_den0", nth_ev(0, e, e + 39, 0), e + 2);
        chk("t3_den1", nth_ev(0, e, e + 39, 1), e + 10);
        chk("t3_den2", nth_ev(0, e, e + 39, 2), e + 18);
        u = nth_ev(1, e, e + 39, 0);
        chk("t3_upd_at", u, e + 7);
        chk("t3_data", 32'(dout_at(u)), 32'(exp_sample(u)));
`ifdef STE_SMP_OVERRUN_CNT_EN
        chk("t3_ovr_start", 32'(ovr_lg[e + 1]), 0);
        chk("t3_ovr_8", 32'(ovr_lg[e + 8]), 3);
        chk("t3_ovr_16", 32'(ovr_lg[e + 16]), 6);
`else
        chk("t3_ovr_8", 32'(ovr_lg[e + 8]), 0);
`endif
        wait_to(e + 900);
`ifdef STE_SMP_OVERRUN_CNT_EN
        chk("t3_ovr_sat", 32'(ovr), 255);
`else
        chk("t3_ovr_sat", 32'(ovr), 0);
`endif
        chk("t3_overlap", den_overlap, 0);

        // Disable one cycle after den; data must be discarded.
        enable = 1'b0;
        idle_cycles(10);
        div = DIVW'(99);
        drp_lat = 4;
        prev = dout;
        enable = 1'b1;
        e = cyc;
        wait_to(e + 3);
        enable = 1'b0;
        wait_to(e + 12);
        chk("t4_den0", nth_ev(0, e, e + 11, 0), e + 2);
        chk("t4_den_cnt", cnt_ev(0, e, e + 11), 1);
        chk("t4_no_upd", cnt_ev(1, e, e + 11), 0);
        chk("t4_busy_rdy", 32'(bit_at(3, e + 6)), 1);
        chk("t4_busy_fall", 32'(bit_at(3, e + 7)), 0);
        chk("t4_dout_hold", 32'(dout_at(e + 11)), 32'(prev));

        // Divider change while enabled.
        idle_cycles(5);
        drp_lat = 2;
        enable = 1'b1;
        e = cyc;
        wait_to(e + 120);
        div = DIVW'(49);
        c = cyc;
        wait_to(e + 320);
        chk("t5_clr_cnt", cnt_ev(2, e, e + 319), 2);
        chk("t5_clr_chg", nth_ev(2, e, e + 319, 1), c + 1);
        chk("t5_den1", nth_ev(0, e, e + 319, 1), e + 102);
        chk("t5_den2", nth_ev(0, e, e + 319, 2), e + 202);
        chk("t5_den3", nth_ev(0, e, e + 319, 3), e + 252);
        chk("t5_den4", nth_ev(0, e, e + 319, 4), e + 302);

        // Reset while waiting on DRP, enable held high through reset.
        enable = 1'b0;
        idle_cycles(5);
        div = DIVW'($urandom_range(20, 60));
        drp_lat = 10;
        enable = 1'b1;
        e = cyc;
        wait_to(e + 5);
        chk("t6_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", 32'(dout), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_den", 32'(drp.drp_den_o), 0);
        chk("t6_rst_flags", 32'({upd, clr, tmo}), 0);
        chk("t6_rst_ovr", 32'(ovr), 0);
        idle_cycles(3);
        rst_n = 1'b1;
        drp_lat = 2;
        r = cyc;
        p = int'(div) + 1;
        wait_to(r + 2 * p + 10);
        chk("t6_den0", nth_ev(0, r, r + 2 * p + 9, 0), r + 2);
        chk("t6_den1", nth_ev(0, r, r + 2 * p + 9, 1), r + 2 + p);
        chk("t6_clr_at", nth_ev(2, r, r + 2 * p + 9, 0), r + 1);
        chk("t6_clr_cnt", cnt_ev(2, r, r + 2 * p + 9), 1);
        u = nth_ev(1, r, r + 2 * p + 9, 0);
        chk("t6_upd_at", u, r + 5);
        chk("t6_data", 32'(dout_at(u)), 32'(exp_sample(u)));

        // Random periods, latencies and data against arithmetic timing.
        for (int it = 0; it < 4; it++) begin
            enable = 1'b0;
            idle_cycles(4);
            div = DIVW'($urandom_range(8, 40));
            lat = int'($urandom_range(1, 4));
            drp_lat = lat;
            p = int'(div) + 1;
            enable = 1'b1;
            e = cyc;
            wait_to(e + 3 * p + 8);
            for (int k = 0; k < 3; k++) begin
                d = nth_ev(0, e, e + 3 * p + 6, k);
                u = nth_ev(1, e, e + 3 * p + 6, k);
                chk("t7_den_at", d, e + 2 + k * p);
                chk("t7_upd_at", u, e + 2 + k * p + lat + 1);
                chk("t7_data", 32'(dout_at(u)), 32'(exp_sample(u)));
            end
        end
        enable = 1'b0;
        idle_cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
